sign_narrow_16to9: RTL and testbench

Signed narrowing stage that converts 16-bit two's-complement datapath values into 9-bit signed fields: immediates and offsets written back into instruction formats. It is the write-direction counterpart of the 9-to-16 sign extension on the decode path. Values that do not fit in 9 bits are flagged and, when compiled in, saturated. Transfers use a valid/ready stream with a 2-entry output buffer (output register plus skid register), so neither `in_ready` nor any output has a combinational path from an input.

---
 rtl/sign_narrow_16to9.sv | 99 +++++++++
 tb/tb_sign_narrow_16to9.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sign_narrow_16to9.sv
// Signed 16->9 narrowing stage with range flag, overflow counter and a 2-entry
// (output + skid) valid/ready buffer. Define SIGN_NARROW_SATURATE_EN to clamp out-of-range samples.
module sign_narrow_16to9 #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 9,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  typedef struct packed {
    logic             ovf;
    logic [OUT_W-1:0] data;
  } samp_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  samp_t  out_reg, skid_reg, nar;
  logic   acc, emit, fits;
  logic [IN_W-OUT_W:0] hi;

  // Both handshake outputs decode straight from the state register.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = out_reg.data;
  assign out_ovf   = out_reg.ovf;

  assign acc  = in_valid & in_ready;
  assign emit = out_valid & out_ready;

  // Fits iff every bit from the sign down to the output sign bit agrees.
  always_comb begin
    hi       = in_data[IN_W-1:OUT_W-1];
    fits     = (&hi) | ~(|hi);
    nar.ovf  = ~fits;
    nar.data = in_data[OUT_W-1:0];
`ifdef SIGN_NARROW_SATURATE_EN
    if (!fits)
      nar.data = in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (acc) state_nxt = ONE;
      ONE: begin
        if (emit && !acc)      state_nxt = EMPTY;
        else if (acc && !emit) state_nxt = TWO;
      end
      TWO:     if (emit) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg  <= '0;
      skid_reg <= '0;
    end else begin
      case (state)
        EMPTY: if (acc) out_reg <= nar;
        ONE: begin
          if (acc && emit) out_reg  <= nar;
          else if (acc)    skid_reg <= nar;
        end
        TWO:     if (emit) out_reg <= skid_reg;
        default: ;
      endcase
    end
  end

  // Clear beats a same-cycle increment; count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    ovf_count <= '0;
    else if (ovf_clr)                           ovf_count <= '0;
    else if (acc && nar.ovf && ovf_count != CNT_MAX) ovf_count <= ovf_count + 1'b1;
  end

endmodule

// File: tb/tb_sign_narrow_16to9.sv
// Randomized + directed bench for sign_narrow_16to9 against a queue-based reference model.
module tb_sign_narrow_16to9;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 0, out_ovf, ovf_clr = 0;
  logic [15:0] in_data = '0;
  logic [8:0]  out_data;
  logic [7:0]  ovf_count;

  int total = 0, bad = 0;
  logic [9:0] q[$];   // {ovf, data} of samples held by the block, oldest first
  int mcnt = 0;

  sign_narrow_16to9 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .ovf_clr(ovf_clr), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference narrowing on the integer value of the sample.
  function automatic logic [9:0] ref_nar(input logic [15:0] d);
    int v;
    logic ovf;
    logic [8:0] r;
    v   = int'($signed(d));
    ovf = (v < -256) || (v > 255);
    r   = 9'(v & 511);
`ifdef SIGN_NARROW_SATURATE_EN
    if (v > 255)  r = 9'd255;
    if (v < -256) r = 9'h100;
`endif
    return {ovf, r};
  endfunction

  task automatic step(input logic iv, input logic [15:0] d, input logic ordy, input logic clr);
    logic acc, emit;
    logic [9:0] e;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; ovf_clr = clr;
    #1;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("ovf_count", ovf_count, mcnt);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0][8:0]);
      chk("out_ovf", out_ovf, q[0][9]);
    end
    acc  = iv && (q.size() < 2);
    emit = (q.size() > 0) && ordy;
    e    = ref_nar(d);
    @(posedge clk);
    if (emit) void'(q.pop_front());
    if (acc) q.push_back(e);
    if (clr) mcnt = 0;
    else if (acc && e[9] && mcnt < 255) mcnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 1, 0);
  endtask

  initial begin
    logic [15:0] d;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;

    // in-range boundaries, streamed back to back
    step(1, 16'h0005, 1, 0); step(1, 16'hFFFB, 1, 0);
    step(1, 16'h00FF, 1, 0); step(1, 16'hFF00, 1, 0);
    idle(2);
    chk("cnt_inrange", ovf_count, 0);

    // out-of-range boundaries
    step(1, 16'h0100, 1, 0); step(1, 16'h7FFF, 1, 0);
    step(1, 16'hFEFF, 1, 0); step(1, 16'h8000, 1, 0);
    idle(2);
    chk("cnt_ovf4", ovf_count, 4);

    // backpressure: third offer must be refused, head held stable
    step(1, 16'h0001, 0, 0); step(1, 16'h0002, 0, 0);
    step(1, 16'h0003, 0, 0); step(1, 16'h0003, 0, 0);
    chk("bp_ready", in_ready, 0);
    chk("bp_head", out_data, 9'h001);
    step(1, 16'h0003, 1, 0); step(0, 16'h0, 1, 0); step(0, 16'h0, 1, 0);
    idle(2);

    // counter saturation, then clear racing an overflowing accept
    for (int i = 0; i < 300; i++) step(1, 16'h4000, 1, 0);
    idle(1);
    chk("cnt_sat", ovf_count, 255);
    step(1, 16'h4000, 1, 1);
    idle(1);
    chk("cnt_clr", ovf_count, 0);

    // randomized traffic biased toward the range edges
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(3))
        0: d = 16'($urandom_range(0, 511)) - 16'd256;
        1: d = 16'($urandom_range(0, 7)) + 16'hFEFC;
        2: d = 16'($urandom_range(0, 7)) + 16'h00FC;
        default: d = 16'($urandom);
      endcase
      step($urandom_range(3) != 0, d, $urandom_range(2) != 0, $urandom_range(40) == 0);
    end
    idle(3);

    // asynchronous reset while holding two samples
    step(1, 16'h0101, 0, 0); step(1, 16'h0022, 0, 0); step(0, 16'h0, 0, 0);
    @(negedge clk);
    in_valid = 0; #2 rst = 1; #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_data", out_data, 0);
    chk("arst_cnt", ovf_count, 0);
    q.delete(); mcnt = 0;
    @(negedge clk) rst = 0;
    step(1, 16'h0007, 1, 0);
    step(0, 16'h0, 1, 0);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim ran past its time limit");
    $fatal(1);
  end
endmodule
